// File: rtl/mul_issue_if.sv
// Bundle of EX, writeback and multiplier-side signals for mul_issue.
// The slave modport is the issue block; the master modport is its surroundings.
interface mul_issue_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic            in_word;
    logic [XLEN-1:0] in_src1;
    logic [XLEN-1:0] in_src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] wb_data;
    logic            mul_in_valid;
    logic            mul_flush;
    logic            mul_mulw;
    logic [1:0]      mul_signed;
    logic [XLEN-1:0] mul_multiplicand;
    logic [XLEN-1:0] mul_multiplier;
    logic            mul_out_ready;
    logic            mul_out_valid;
    logic [XLEN-1:0] mul_result_hi;
    logic [XLEN-1:0] mul_result_lo;

    modport slave (
        input  in_valid, in_op, in_word, in_src1, in_src2, flush, out_ready,
               mul_out_ready, mul_out_valid, mul_result_hi, mul_result_lo,
        output in_ready, out_valid, wb_data, mul_in_valid, mul_flush, mul_mulw,
               mul_signed, mul_multiplicand, mul_multiplier
    );

    modport master (
        output in_valid, in_op, in_word, in_src1, in_src2, flush, out_ready,
               mul_out_ready, mul_out_valid, mul_result_hi, mul_result_lo,
        input  in_ready, out_valid, wb_data, mul_in_valid, mul_flush, mul_mulw,
               mul_signed, mul_multiplicand, mul_multiplier
    );
endinterface

// File: rtl/mul_issue.sv
// EX-stage front end for the iterative Booth multiplier: decode, issue, capture, writeback hold.
// Optional MUL_REUSE_EN adds a one-entry product cache so a repeated operand set skips the multiplier.
module mul_issue #(
    parameter int XLEN = 64
) (
    input logic       clock,
    input logic       reset,
    mul_issue_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state_q, state_d;

    logic            load_p1, cap_p2, hit_load;
    logic            in_ready_c, out_valid_c, mul_in_valid_c, mul_flush_c;

    logic [1:0]      signed_p0;
    logic            mulw_p0, sel_hi_p0, hit_p0;
    logic [XLEN-1:0] mcand_p0, mplier_p0, cache_res_p0;

    logic [1:0]      signed_p1;
    logic            mulw_p1, sel_hi_p1;
    logic [XLEN-1:0] mcand_p1, mplier_p1;

    logic [XLEN-1:0] result_p2;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] select_result(input logic [XLEN-1:0] hi,
                                                      input logic [XLEN-1:0] lo,
                                                      input logic            sel_hi,
                                                      input logic            mulw);
        if (mulw)
            return sext32(lo);
        return sel_hi ? hi : lo;
    endfunction

    // p0: combinational decode of the offered op
    always_comb begin
        signed_p0 = 2'b11;
        mulw_p0   = bus.in_word;
        sel_hi_p0 = (bus.in_op != 2'd0) && !bus.in_word;
        mcand_p0  = bus.in_src1;
        mplier_p0 = bus.in_src2;
        case (bus.in_op)
            2'd2:    signed_p0 = 2'b10;
            2'd3:    signed_p0 = 2'b00;
            default: signed_p0 = 2'b11;
        endcase
        if (bus.in_word) begin
            signed_p0 = 2'b11;
            mcand_p0  = sext32(bus.in_src1);
            mplier_p0 = sext32(bus.in_src2);
        end
    end

`ifdef MUL_REUSE_EN
    logic            cache_vld;
    logic [1:0]      cache_signed;
    logic            cache_mulw;
    logic [XLEN-1:0] cache_a, cache_b, cache_hi, cache_lo;

    assign hit_p0 = cache_vld && (cache_a == mcand_p0) && (cache_b == mplier_p0)
                    && (cache_signed == signed_p0) && (cache_mulw == mulw_p0);
    assign cache_res_p0 = select_result(cache_hi, cache_lo, sel_hi_p0, mulw_p0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cache_vld    <= 1'b0;
            cache_signed <= 2'b00;
            cache_mulw   <= 1'b0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_hi     <= '0;
            cache_lo     <= '0;
        end else if (bus.flush) begin
            cache_vld <= 1'b0;
        end else if (cap_p2) begin
            cache_vld    <= 1'b1;
            cache_signed <= signed_p1;
            cache_mulw   <= mulw_p1;
            cache_a      <= mcand_p1;
            cache_b      <= mplier_p1;
            cache_hi     <= bus.mul_result_hi;
            cache_lo     <= bus.mul_result_lo;
        end
    end
`else
    assign hit_p0       = 1'b0;
    assign cache_res_p0 = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        load_p1        = 1'b0;
        cap_p2         = 1'b0;
        hit_load       = 1'b0;
        in_ready_c     = (state_q == IDLE);
        out_valid_c    = (state_q == DONE);
        mul_in_valid_c = (state_q == ISSUE);
        mul_flush_c    = bus.flush && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    load_p1 = 1'b1;
                    if (hit_p0) begin
                        hit_load = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: if (bus.mul_out_ready) state_d = WAIT;
            WAIT: begin
                if (bus.mul_out_valid) begin
                    cap_p2  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // flush overrides every transition, including a completing writeback
        if (bus.flush) begin
            state_d  = IDLE;
            load_p1  = 1'b0;
            cap_p2   = 1'b0;
            hit_load = 1'b0;
        end
    end

    // p1: operands and controls held for the multiplier; p2: selected result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            signed_p1 <= 2'b00;
            mulw_p1   <= 1'b0;
            sel_hi_p1 <= 1'b0;
            mcand_p1  <= '0;
            mplier_p1 <= '0;
            result_p2 <= '0;
        end else begin
            if (load_p1) begin
                signed_p1 <= signed_p0;
                mulw_p1   <= mulw_p0;
                sel_hi_p1 <= sel_hi_p0;
                mcand_p1  <= mcand_p0;
                mplier_p1 <= mplier_p0;
            end
            if (cap_p2)
                result_p2 <= select_result(bus.mul_result_hi, bus.mul_result_lo, sel_hi_p1, mulw_p1);
            else if (hit_load)
                result_p2 <= cache_res_p0;
        end
    end

    assign bus.in_ready         = in_ready_c;
    assign bus.out_valid        = out_valid_c;
    assign bus.wb_data          = out_valid_c ? result_p2 : '0;
    assign bus.mul_in_valid     = mul_in_valid_c;
    assign bus.mul_flush        = mul_flush_c;
    assign bus.mul_mulw         = mulw_p1;
    assign bus.mul_signed       = signed_p1;
    assign bus.mul_multiplicand = mcand_p1;
    assign bus.mul_multiplier   = mplier_p1;
endmodule

// File: doc/mul_issue.md
Name: mul_issue

Overview:
- EX-stage front end for the iterative radix-4 Booth multiplier. It sits between the execute pipeline and the multiplier.
- Decodes RV64M multiply ops (MUL/MULH/MULHSU/MULHU/MULW) into multiplier controls and conditions the operands.
- Drives the multiplier's single-pulse valid handshake and captures its one-cycle result pulse.
- Selects and sign-extends the result, then holds it under a valid/ready handshake to the writeback stage.

Parameters:
XLEN, 64, operand/result width; only 64 is supported.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  EX offers a multiply op
in_ready  out  1  block can accept an op (high only in IDLE)
in_op  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU
in_word  in  1  32-bit op (MULW); only legal with in_op=0
in_src1  in  64  rs1 value
in_src2  in  64  rs2 value
flush  in  1  cancel any in-flight op
out_valid  out  1  wb_data valid
out_ready  in  1  writeback accepts wb_data
wb_data  out  64  final rd value
mul_in_valid  out  1  to multiplier in_valid
mul_flush  out  1  to multiplier flush
mul_mulw  out  1  to multiplier mulw
mul_signed  out  2  to multiplier mul_signed
mul_multiplicand  out  64  rs1 after conditioning
mul_multiplier  out  64  rs2 after conditioning
mul_out_ready  in  1  multiplier ready
mul_out_valid  in  1  multiplier result pulse (one cycle)
mul_result_hi  in  64  product[127:64]
mul_result_lo  in  64  product[63:0]

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is asynchronous and active-high.
- Reset values:
  - state=IDLE.
  - in_ready=1, out_valid=0, wb_data=0.
  - mul_in_valid=0, mul_flush=0.
  - All operand and control registers cleared to 0.
  - A reset in any state aborts the op with no output.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: when in_valid & in_ready & !flush, latch the decoded op and go to ISSUE.
- Decode (registered at acceptance):
  - mul_signed: MUL=2'b11, MULH=2'b11, MULHSU=2'b10 (rs1 signed, rs2 unsigned), MULHU=2'b00.
  - in_word=1: mul_mulw=1, mul_signed=2'b11, each operand sign-extended from bit 31.
  - in_word=0: operands passed through unchanged.
  - multiplicand=rs1, multiplier=rs2.
  - Result select: lo for MUL/MULW, hi for MULH/MULHSU/MULHU.
- ISSUE:
  - mul_in_valid=1 while the state is ISSUE.
  - When mul_out_ready is sampled high, go to WAIT.
  - mul_in_valid is low in the following cycle; this guarantees a single-cycle valid pulse at acceptance.
- WAIT:
  - mul_in_valid=0.
  - On mul_out_valid, capture the result into a 64-bit register and go to DONE:
    - lo-select: mul_result_lo.
    - hi-select: mul_result_hi.
    - MULW: {{32{lo[31]}}, lo[31:0]}.
- DONE:
  - out_valid=1 and wb_data is held stable until out_ready.
  - On out_valid & out_ready, go to IDLE.
  - A new op cannot be accepted in the same cycle (in_ready=0 in DONE).
- Latency (no backpressure, no reuse): acceptance at cycle N → mul_in_valid at N+1 → out_valid one cycle after the multiplier's mul_out_valid pulse.
- Flush:
  - In any state, flush forces state=IDLE next cycle and drops out_valid.
  - Any pending result is discarded.
  - mul_flush = flush & (state!=IDLE), combinational.
  - flush together with in_valid in IDLE: nothing is accepted.
  - flush in DONE together with out_ready: the result is discarded (flush wins).
- mul_out_valid is ignored outside WAIT; a stray pulse after a flush must not produce output.
- wb_data is 0 whenever out_valid=0.

Optional Feature:
- Macro: MUL_REUSE_EN.
- When defined:
  - The block keeps a one-entry cache: the last issued conditioned operands, mul_signed and mulw, plus the full 128-bit product and a cache-valid bit.
  - An accepted op whose conditioned operands, mul_signed and mulw all match a valid cache entry skips ISSUE/WAIT and goes to DONE in the cycle after acceptance, with the result selected from the cached product (serves the MULH-then-MUL idiom).
  - The cache is filled at capture in WAIT.
  - The cache is invalidated by reset and by any flush.
- When not defined: every op is issued to the multiplier and no cache storage exists.

Test Plan:
- MUL 3×5, out_ready=1 → single mul_in_valid pulse; wb_data=0x000000000000000F; returns to IDLE.
- MULH 0xFFFFFFFFFFFFFFFF×0xFFFFFFFFFFFFFFFF → mul_signed=11; wb_data=0x0.
- MULHU 0xFFFFFFFFFFFFFFFF×2 → mul_signed=00, wb_data=0x1. MULHSU -1×2 → mul_signed=10, wb_data=0xFFFFFFFFFFFFFFFF.
- MULW src1=0x123456787FFFFFFF, src2=2 → operands sign-extended to 0x7FFFFFFF and 2, mulw=1; wb_data=0xFFFFFFFFFFFFFFFE.
- flush asserted in WAIT → mul_flush=1 for that cycle; IDLE next cycle; a later mul_out_valid produces no out_valid. Async reset in ISSUE → in_ready=1 and mul_in_valid=0 immediately.
- out_ready held 0 for 5 cycles in DONE → wb_data stable, in_ready=0. With MUL_REUSE_EN: MULH a,b then MUL a,b → second op has no mul_in_valid and out_valid one cycle after acceptance with the correct low word.
